// File: rtl/alu16_seq.sv
// alu16_seq: sequences 16-bit ADD HL,rr / INC rr / DEC rr / ADD SP,e8
// over the shared 8-bit ALU as a low-byte pass followed by a high-byte pass.

package alu16_seq_pkg;
  typedef enum logic [2:0] {
    alu_NOP = 3'd0,
    alu_ADD = 3'd1,
    alu_ADC = 3'd2,
    alu_INC = 3'd3,
    alu_DEC = 3'd4,
    alu_B   = 3'd5
  } alu_op_t;
endpackage

module alu16_seq
  import alu16_seq_pkg::*;
#(
  parameter bit INCDEC_SHORT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic [1:0]    op_sel,
  input  logic [15:0]   opnd_a,
  input  logic [15:0]   opnd_b,
  input  logic [3:0]    flags_in,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output logic [3:0]    flags_out,
  output logic [7:0]    alu_op_A,
  output logic [7:0]    alu_op_B,
  output alu_op_t       alu_op_code,
  output logic [3:0]    alu_curr_flags,
  input  logic [7:0]    alu_res_in,
  input  logic [3:0]    alu_flags_in
);

  localparam logic [1:0] OP_ADD_HL = 2'b00;
  localparam logic [1:0] OP_INC16  = 2'b01;
  localparam logic [1:0] OP_DEC16  = 2'b10;
  localparam logic [1:0] OP_ADD_SP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state, state_n;
  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [3:0]  flags_q;
  logic        carry_q;   // carry out of the LO pass (or INC/DEC borrow/overflow)
  logic        lo_h_q;    // half-carry of the LO pass, reported by ADD SP,e8
  logic        lo_carry;
  logic        is_incdec;
  logic        take_short;

  // Z and N from the ALU are never reported; 16-bit Z/N come from the rules below.
  logic unused_alu_zn;
  assign unused_alu_zn = ^alu_flags_in[3:2];

  assign is_incdec = (op_q == OP_INC16) || (op_q == OP_DEC16);

  // Carry out of the LO pass: INC wraps when the low byte becomes 00, DEC when it was 00.
  always_comb begin
    lo_carry = alu_flags_in[0];
    if (op_q == OP_INC16)      lo_carry = (alu_res_in == 8'h00);
    else if (op_q == OP_DEC16) lo_carry = (a_q[7:0] == 8'h00);
  end

  assign take_short = INCDEC_SHORT && is_incdec && !lo_carry;

  // Next-state and ALU drive for the current pass.
  always_comb begin
    state_n        = state;
    alu_op_code    = alu_NOP;
    alu_op_A       = 8'h00;
    alu_op_B       = 8'h00;
    alu_curr_flags = flags_q;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_LO;
      end
      S_LO: begin
        busy = 1'b1;
        unique case (op_q)
          OP_INC16: begin
            alu_op_code = alu_INC;
            alu_op_B    = a_q[7:0];
          end
          OP_DEC16: begin
            alu_op_code = alu_DEC;
            alu_op_B    = a_q[7:0];
          end
          default: begin
            alu_op_code = alu_ADD;
            alu_op_A    = a_q[7:0];
            alu_op_B    = b_q[7:0];
          end
        endcase
        state_n = take_short ? S_DONE : S_HI;
      end
      S_HI: begin
        busy = 1'b1;
        unique case (op_q)
          OP_ADD_HL: begin
            alu_op_code       = alu_ADC;
            alu_op_A          = a_q[15:8];
            alu_op_B          = b_q[15:8];
            alu_curr_flags[0] = carry_q;
          end
          OP_ADD_SP: begin
            alu_op_code       = alu_ADC;
            alu_op_A          = a_q[15:8];
            alu_op_B          = {8{b_q[7]}};
            alu_curr_flags[0] = carry_q;
          end
          OP_INC16: begin
            alu_op_code = carry_q ? alu_INC : alu_B;
            alu_op_B    = a_q[15:8];
          end
          default: begin
            alu_op_code = carry_q ? alu_DEC : alu_B;
            alu_op_B    = a_q[15:8];
          end
        endcase
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, operand latch and per-pass result/flag capture.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      flags_q   <= 4'h0;
      carry_q   <= 1'b0;
      lo_h_q    <= 1'b0;
      result    <= 16'h0000;
      flags_out <= 4'h0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_sel;
            a_q     <= opnd_a;
            b_q     <= opnd_b;
            flags_q <= flags_in;
          end
        end
        S_LO: begin
          result[7:0] <= alu_res_in;
          carry_q     <= lo_carry;
          lo_h_q      <= alu_flags_in[1];
          if (take_short) begin
            result[15:8] <= a_q[15:8];
            flags_out    <= flags_q;
          end
        end
        S_HI: begin
          result[15:8] <= alu_res_in;
          unique case (op_q)
            OP_ADD_HL: flags_out <= {flags_q[3], 1'b0, alu_flags_in[1], alu_flags_in[0]};
            OP_ADD_SP: flags_out <= {2'b00, lo_h_q, carry_q};
            default:   flags_out <= flags_q;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
